// File: rtl/enokida_trace_pkg.sv
// Shared constants, the trace record type and sizing helpers for the trace feeder.
package enokida_trace_pkg;

    localparam int TRACE_WIDTH = 160;

    typedef logic [TRACE_WIDTH-1:0] trace_record_t;

    // Occupancy must count 0..depth inclusive, hence one bit more than the pointers.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/enokida_trace_ram.sv
// Record storage: DEPTH x WIDTH register array, one synchronous write port,
// one combinational read port. Contents are deliberately not reset.
module enokida_trace_ram #(
    parameter int WIDTH = 160,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    import enokida_trace_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed slot when a record is accepted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/enokida_trace_feeder.sv
// Trace feeder: circular buffer between the processor tracer and the
// trace-assisted cache, with backpressure, high-water lock and stall statistics.
module enokida_trace_feeder #(
    parameter int TRACE_WIDTH = enokida_trace_pkg::TRACE_WIDTH,
    parameter int DEPTH       = 8,
    parameter int HIGH_WATER  = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tracer_valid_i,
    input  logic [TRACE_WIDTH-1:0]     tracer_record_i,
    output logic                       tracer_ready_o,
    input  logic                       capture_en_i,
    input  logic                       flush_i,
    input  logic                       trace_pop_i,
    output logic [TRACE_WIDTH-1:0]     trace_out_o,
    output logic                       trace_ready_o,
    output logic                       trace_capture_enable_o,
    output logic                       lock_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [31:0]                stall_count_o,
    output logic                       underflow_o
);
    import enokida_trace_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [OCC_W-1:0]       occ_reg;
    logic [31:0]            stall_count_reg;
    logic                   underflow_reg;
    logic                   capture_en_reg;
    logic [TRACE_WIDTH-1:0] ram_rd_data;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic stall;

    assign empty = (occ_reg == '0);
    assign full  = (occ_reg == OCC_W'(DEPTH));

    // Ready depends only on registered state, so the tracer sees no combinational path.
    assign tracer_ready_o = !full && capture_en_reg;
    assign push           = tracer_valid_i && tracer_ready_o;
    assign pop            = trace_pop_i && !empty;
    // Only genuine backpressure counts; offers while capture is off are ignored.
    assign stall          = tracer_valid_i && capture_en_reg && !tracer_ready_o;

    enokida_trace_ram #(
        .WIDTH (TRACE_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push && !flush_i),
        .wr_addr (wr_ptr_reg),
        .wr_data (tracer_record_i),
        .rd_addr (rd_ptr_reg),
        .rd_data (ram_rd_data)
    );

    // The array is not reset, so mask the head while empty to present zeros after reset.
    assign trace_out_o            = empty ? '0 : ram_rd_data;
    assign trace_ready_o          = !empty;
    assign lock_o                 = (occ_reg >= OCC_W'(HIGH_WATER));
    assign occupancy_o            = occ_reg;
    assign stall_count_o          = stall_count_reg;
    assign underflow_o            = underflow_reg;
    assign trace_capture_enable_o = capture_en_reg;

    // Pointers, occupancy, statistics and flags; flush beats push/pop but keeps statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            occ_reg         <= '0;
            stall_count_reg <= '0;
            underflow_reg   <= 1'b0;
            capture_en_reg  <= 1'b0;
        end else begin
            capture_en_reg <= capture_en_i;

            if (stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
                stall_count_reg <= stall_count_reg + 32'd1;
            end

            if (trace_pop_i && empty) begin
                underflow_reg <= 1'b1;
            end

            if (flush_i) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                occ_reg    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (push && !pop) begin
                    occ_reg <= occ_reg + 1'b1;
                end else if (pop && !push) begin
                    occ_reg <= occ_reg - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_enokida_trace_feeder.sv
// Directed self-checking bench for the trace feeder (DEPTH=8, HIGH_WATER=6).
module tb_enokida_trace_feeder;

    localparam int TW = 160;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tracer_valid_i;
    logic [TW-1:0] tracer_record_i;
    logic          tracer_ready_o;
    logic          capture_en_i;
    logic          flush_i;
    logic          trace_pop_i;
    logic [TW-1:0] trace_out_o;
    logic          trace_ready_o;
    logic          trace_capture_enable_o;
    logic          lock_o;
    logic [3:0]    occupancy_o;
    logic [31:0]   stall_count_o;
    logic          underflow_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    enokida_trace_feeder #(
        .TRACE_WIDTH (TW),
        .DEPTH       (8),
        .HIGH_WATER  (6)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .tracer_valid_i         (tracer_valid_i),
        .tracer_record_i        (tracer_record_i),
        .tracer_ready_o         (tracer_ready_o),
        .capture_en_i           (capture_en_i),
        .flush_i                (flush_i),
        .trace_pop_i            (trace_pop_i),
        .trace_out_o            (trace_out_o),
        .trace_ready_o          (trace_ready_o),
        .trace_capture_enable_o (trace_capture_enable_o),
        .lock_o                 (lock_o),
        .occupancy_o            (occupancy_o),
        .stall_count_o          (stall_count_o),
        .underflow_o            (underflow_o)
    );

    task automatic check(input string tag, input logic [TW-1:0] observed, input logic [TW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, ".tracer_ready"}, tracer_ready_o, 0);
        check({where, ".trace_ready"}, trace_ready_o, 0);
        check({where, ".cap_en"}, trace_capture_enable_o, 0);
        check({where, ".lock"}, lock_o, 0);
        check({where, ".occ"}, occupancy_o, 0);
        check({where, ".stall"}, stall_count_o, 0);
        check({where, ".underflow"}, underflow_o, 0);
        check({where, ".trace_out"}, trace_out_o, 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        tracer_valid_i  = 1'b0;
        tracer_record_i = '0;
        capture_en_i    = 1'b0;
        flush_i         = 1'b0;
        trace_pop_i     = 1'b0;

        // Reset state
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Enable capture, push A1 and A2, pop both
        capture_en_i = 1'b1;
        step();
        check("cap_en_latency", trace_capture_enable_o, 1);
        check("ready_after_en", tracer_ready_o, 1);
        tracer_valid_i = 1'b1; tracer_record_i = 160'hA1;
        step();
        $display("push rec=a1 occ=%0d", occupancy_o);
        check("a1_head", trace_out_o, 160'hA1);
        check("a1_trace_ready", trace_ready_o, 1);
        tracer_record_i = 160'hA2;
        step();
        $display("push rec=a2 occ=%0d", occupancy_o);
        tracer_valid_i = 1'b0;
        check("a2_occ", occupancy_o, 2);
        check("a2_head_still_a1", trace_out_o, 160'hA1);
        trace_pop_i = 1'b1;
        step();
        $display("pop head=%0h occ=%0d", trace_out_o, occupancy_o);
        check("pop1_head", trace_out_o, 160'hA2);
        check("pop1_occ", occupancy_o, 1);
        step();
        $display("pop occ=%0d", occupancy_o);
        trace_pop_i = 1'b0;
        check("pop2_trace_ready", trace_ready_o, 0);
        check("pop2_occ", occupancy_o, 0);

        // Fill to full: lock after 6th push, ready low after 8th
        tracer_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tracer_record_i = TW'(32'hC0 + i);
            step();
            $display("push rec=%0h occ=%0d lock=%0d", 32'hC0 + i, occupancy_o, lock_o);
            if (i == 4) check("lock_after_5", lock_o, 0);
            if (i == 5) check("lock_after_6", lock_o, 1);
        end
        check("full_occ", occupancy_o, 8);
        check("full_ready_low", tracer_ready_o, 0);
        check("full_head", trace_out_o, 160'hC0);
        for (int i = 0; i < 5; i++) begin
            step();
            $display("stall cycle stall_count=%0d", stall_count_o);
        end
        check("stall_5", stall_count_o, 5);
        check("occ_unchanged_when_full", occupancy_o, 8);

        // Full: pop with tracer still offering D0
        tracer_record_i = 160'hD0;
        trace_pop_i = 1'b1;
        step();
        $display("pop on full occ=%0d ready=%0d", occupancy_o, tracer_ready_o);
        trace_pop_i = 1'b0;
        check("full_pop_ready", tracer_ready_o, 1);
        check("full_pop_occ", occupancy_o, 7);
        check("full_pop_head", trace_out_o, 160'hC1);
        check("full_pop_stall", stall_count_o, 6);
        step();
        $display("push rec=d0 occ=%0d", occupancy_o);
        tracer_valid_i = 1'b0;
        check("refill_occ", occupancy_o, 8);
        trace_pop_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_order", trace_out_o, (i < 7) ? TW'(32'hC1 + i) : TW'(160'hD0));
            step();
            $display("pop occ=%0d", occupancy_o);
        end
        trace_pop_i = 1'b0;
        check("drained_empty", trace_ready_o, 0);

        // Occupancy 3 with simultaneous push and pop for 20 cycles
        tracer_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tracer_record_i = TW'(32'hE00 + i);
            step();
            $display("push rec=%0h occ=%0d", 32'hE00 + i, occupancy_o);
        end
        check("steady_start_occ", occupancy_o, 3);
        trace_pop_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("steady_head", trace_out_o, TW'(32'hE00 + k));
            tracer_record_i = TW'(32'hE03 + k);
            step();
            $display("push+pop rec=%0h occ=%0d", 32'hE03 + k, occupancy_o);
            check("steady_occ", occupancy_o, 3);
        end
        tracer_valid_i = 1'b0;
        for (int k = 20; k < 23; k++) begin
            check("steady_tail", trace_out_o, TW'(32'hE00 + k));
            step();
            $display("pop occ=%0d", occupancy_o);
        end
        check("steady_drained", occupancy_o, 0);

        // Pop while empty -> sticky underflow; then flush with occupancy 4
        step();
        $display("pop on empty underflow=%0d", underflow_o);
        trace_pop_i = 1'b0;
        check("underflow_set", underflow_o, 1);
        check("underflow_occ", occupancy_o, 0);
        step();
        check("underflow_sticky", underflow_o, 1);
        tracer_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tracer_record_i = TW'(32'hF0 + i);
            step();
            $display("push rec=%0h occ=%0d", 32'hF0 + i, occupancy_o);
        end
        tracer_valid_i = 1'b0;
        check("preflush_occ", occupancy_o, 4);
        flush_i = 1'b1;
        step();
        $display("flush occ=%0d", occupancy_o);
        flush_i = 1'b0;
        check("flush_occ", occupancy_o, 0);
        check("flush_trace_ready", trace_ready_o, 0);
        check("flush_keeps_underflow", underflow_o, 1);
        check("flush_keeps_stall", stall_count_o, 6);

        // Async reset mid-burst at occupancy 5
        tracer_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tracer_record_i = TW'(32'h50 + i);
            step();
            $display("push rec=%0h occ=%0d", 32'h50 + i, occupancy_o);
        end
        check("preburst_occ", occupancy_o, 5);
        check("preburst_lock", lock_o, 0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset asserted");
        check_reset_outputs("midreset");
        tracer_valid_i = 1'b0;
        rst_n = 1'b1;
        step();
        check("post_reset_cap_en", trace_capture_enable_o, 1);
        tracer_valid_i = 1'b1; tracer_record_i = 160'hB7;
        step();
        $display("push rec=b7 occ=%0d", occupancy_o);
        tracer_valid_i = 1'b0;
        check("b7_head", trace_out_o, 160'hB7);
        check("b7_occ", occupancy_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
